// File: rtl/mem_unit_if.sv
// mem_unit_if: bundles the command side (from the control unit / ALU) and the
// RAM port of the load/store stage into one interface.
//   slave  : view used by mem_unit (commands and RAM responses in, RAM request
//            and results out)
//   master : view used by the surrounding environment (control unit and RAM)
// Signals:
//   en, is_load, is_store, byte_mode, sign_ext, addr, wdata : operation request
//   ram_req, ram_we, ram_addr, ram_wdata, ram_rdata, ram_ack : RAM port
//   rdata_o, done, err, busy                                 : results / status
interface mem_unit_if;
   logic        en;
   logic        is_load;
   logic        is_store;
   logic        byte_mode;
   logic        sign_ext;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic        ram_req;
   logic        ram_we;
   logic [14:0] ram_addr;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata;
   logic        ram_ack;
   logic [15:0] rdata_o;
   logic        done;
   logic        err;
   logic        busy;

   modport slave (
      input  en, is_load, is_store, byte_mode, sign_ext, addr, wdata,
      input  ram_rdata, ram_ack,
      output ram_req, ram_we, ram_addr, ram_wdata,
      output rdata_o, done, err, busy
   );

   modport master (
      output en, is_load, is_store, byte_mode, sign_ext, addr, wdata,
      output ram_rdata, ram_ack,
      input  ram_req, ram_we, ram_addr, ram_wdata,
      input  rdata_o, done, err, busy
   );
endinterface

// File: rtl/mem_unit.sv
// mem_unit: load/store stage of the 16-bit core. Accepts one memory operation
// while idle, turns the byte address into a word access on the RAM, performs
// byte stores as read-modify-write, and returns extended load data.
// Ports:
//   clk  : system clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : mem_unit_if.slave (operation request, RAM port, results/status)
// Parameter:
//   TIMEOUT : cycles a RAM request may wait for ack before it is aborted
module mem_unit #(
   parameter int unsigned TIMEOUT = 15
) (
   input logic      clk,
   input logic      rst,
   mem_unit_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Last wait-counter value before an unacknowledged request is abandoned.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        is_load_q, is_load_d;
   logic        byte_q, byte_d;
   logic        sext_q, sext_d;
   logic        addr0_q, addr0_d;
   logic [7:0]  wbyte_q, wbyte_d;
   logic        ram_req_q, ram_req_d;
   logic        ram_we_q, ram_we_d;
   logic [14:0] ram_addr_q, ram_addr_d;
   logic [15:0] ram_wdata_q, ram_wdata_d;
   logic [15:0] rdata_q, rdata_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        busy_q, busy_d;
   logic [7:0]  lane_byte;
   logic [15:0] merged_word;

   // Next-state, RAM request and result computation.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      is_load_d   = is_load_q;
      byte_d      = byte_q;
      sext_d      = sext_q;
      addr0_d     = addr0_q;
      wbyte_d     = wbyte_q;
      ram_req_d   = ram_req_q;
      ram_we_d    = ram_we_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      rdata_d     = rdata_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      // Byte lane selected by the low address bit, and the byte-store merge
      // that keeps the other lane of the word just read.
      lane_byte   = addr0_q ? bus.ram_rdata[15:8] : bus.ram_rdata[7:0];
      merged_word = addr0_q ? {wbyte_q, bus.ram_rdata[7:0]}
                            : {bus.ram_rdata[15:8], wbyte_q};
      case (state_q)
         S_IDLE: begin
            if (bus.en) begin
               is_load_d   = bus.is_load;
               byte_d      = bus.byte_mode;
               sext_d      = bus.sign_ext;
               addr0_d     = bus.addr[0];
               wbyte_d     = bus.wdata[7:0];
               ram_addr_d  = bus.addr[15:1];
               ram_wdata_d = bus.wdata;
               cnt_d       = 8'd0;
               if (bus.is_load && bus.is_store) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else if (!bus.is_load && !bus.is_store) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else if (!bus.byte_mode && bus.addr[0]) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else if (bus.is_load || bus.byte_mode) begin
                  // Loads and byte stores both start with a read.
                  state_d   = S_RD;
                  ram_req_d = 1'b1;
                  ram_we_d  = 1'b0;
               end else begin
                  state_d   = S_WR;
                  ram_req_d = 1'b1;
                  ram_we_d  = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RD: begin
            if (bus.ram_ack) begin
               cnt_d = 8'd0;
               if (is_load_q) begin
                  state_d   = S_DONE;
                  ram_req_d = 1'b0;
                  done_d    = 1'b1;
                  if (byte_q) begin
                     rdata_d = sext_q ? {{8{lane_byte[7]}}, lane_byte}
                                      : {8'h00, lane_byte};
                  end else begin
                     rdata_d = bus.ram_rdata;
                  end
               end else begin
                  // Byte store: write back the merged word, request stays up.
                  state_d     = S_WR;
                  ram_we_d    = 1'b1;
                  ram_wdata_d = merged_word;
               end
            end else if (cnt_q == TO_LAST) begin
               state_d   = S_DONE;
               ram_req_d = 1'b0;
               ram_we_d  = 1'b0;
               done_d    = 1'b1;
               err_d     = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_WR: begin
            if (bus.ram_ack) begin
               state_d   = S_DONE;
               ram_req_d = 1'b0;
               ram_we_d  = 1'b0;
               done_d    = 1'b1;
            end else if (cnt_q == TO_LAST) begin
               state_d   = S_DONE;
               ram_req_d = 1'b0;
               ram_we_d  = 1'b0;
               done_d    = 1'b1;
               err_d     = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d   = S_IDLE;
            ram_req_d = 1'b0;
            ram_we_d  = 1'b0;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and registered outputs, cleared by the synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 8'd0;
         is_load_q   <= 1'b0;
         byte_q      <= 1'b0;
         sext_q      <= 1'b0;
         addr0_q     <= 1'b0;
         wbyte_q     <= 8'd0;
         ram_req_q   <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= 15'd0;
         ram_wdata_q <= 16'd0;
         rdata_q     <= 16'd0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         is_load_q   <= is_load_d;
         byte_q      <= byte_d;
         sext_q      <= sext_d;
         addr0_q     <= addr0_d;
         wbyte_q     <= wbyte_d;
         ram_req_q   <= ram_req_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         rdata_q     <= rdata_d;
         done_q      <= done_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.ram_req   = ram_req_q;
   assign bus.ram_we    = ram_we_q;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_wdata = ram_wdata_q;
   assign bus.rdata_o   = rdata_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.busy      = busy_q;
endmodule
